block_match_sad_engine: RTL and testbench

Responder side of the block-match start/done handshake. Accepts one start request carrying a block address, a search-window address and a block index. Fetches the 16×16 reference block and the matching 16 search-window rows from two frame-buffer read ports. Computes the sum of absolute differences (SAD) for every horizontal candidate offset, then reports the best offset with its SAD and index. One instance serves each eye: left and right.

---
 rtl/block_match_sad_engine_if.sv | 24 ++
 rtl/block_match_sad_engine.sv | 126 ++++++++++++
 tb/tb_block_match_sad_engine.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/block_match_sad_engine_if.sv
// block_match_sad_engine_if: start/done handshake, result and frame-buffer read ports
interface block_match_sad_engine_if #(parameter int rd_port_w = 8);
  logic                   bm_start;
  logic [15:0]            blk_addr;
  logic [15:0]            srch_addr;
  logic [15:0]            blk_index;
  logic                   bm_done;
  logic [15:0]            blk_rd_addr;
  logic [rd_port_w*8-1:0] blk_rd_data;
  logic [15:0]            srch_rd_addr;
  logic [rd_port_w*8-1:0] srch_rd_data;
  logic                   result_valid;
  logic [5:0]             result_disp;
  logic [15:0]            result_sad;
  logic [15:0]            result_index;
  modport master (
    output bm_start, blk_addr, srch_addr, blk_index, blk_rd_data, srch_rd_data,
    input  bm_done, blk_rd_addr, srch_rd_addr, result_valid, result_disp, result_sad, result_index
  );
  modport slave (
    input  bm_start, blk_addr, srch_addr, blk_index, blk_rd_data, srch_rd_data,
    output bm_done, blk_rd_addr, srch_rd_addr, result_valid, result_disp, result_sad, result_index
  );
endinterface

// File: rtl/block_match_sad_engine.sv
// block_match_sad_engine: 16x16 block vs. search-band SAD over all horizontal offsets, best offset reported
module block_match_sad_engine #(
  parameter int rd_port_w    = 8,
  parameter int block_width  = 16,
  parameter int block_height = 16,
  parameter int search_blk_w = 64,
  parameter int search_blk_h = 32,
  parameter int blk_stride   = 30,
  parameter int srch_stride  = 38,
  parameter int rd_latency   = 2
) (
  input logic clk,
  input logic reset,
  block_match_sad_engine_if.slave bus
);
  localparam int NW   = search_blk_w / rd_port_w;
  localparam int BWW  = block_width / rd_port_w;
  localparam int NK   = search_blk_w - block_width + 1;
  localparam int VOFS = (search_blk_h - block_height) / 2;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ACCUM, SEARCH, DONE} state_t;
  state_t                  state;
  logic [15:0]             bbase, sbase, idx, best;
  logic [4:0]              r;
  logic [5:0]              cnt, bestk;
  logic                    ready, upd;
  logic [rd_latency-1:0]   sv, bv;
  logic [search_blk_w*8-1:0] srow;
  logic [block_width*8-1:0]  brow;
  logic [15:0]             acc [NK];
  logic [11:0]             rsad [NK];
  function automatic logic [7:0] ad(input logic [7:0] a, input logic [7:0] b);
    return a > b ? a - b : b - a;
  endfunction
  // row SAD of the buffered block row against every candidate offset
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      rsad[k] = '0;
      for (int c = 0; c < block_width; c++)
        rsad[k] = rsad[k] + {4'b0, ad(brow[c*8+:8], srow[(c+k)*8+:8])};
    end
    upd = (cnt == 6'd0) || (acc[cnt] < best);
  end
  // control FSM, read-data capture pipe, accumulators and best-offset scan
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      ready             <= 1'b1;
      cnt               <= '0;
      r                 <= '0;
      sv                <= '0;
      bv                <= '0;
      bus.bm_done       <= 1'b1;
      bus.result_valid  <= 1'b0;
      bus.result_disp   <= '0;
      bus.result_sad    <= '0;
      bus.result_index  <= '0;
      bus.blk_rd_addr   <= '0;
      bus.srch_rd_addr  <= '0;
    end else begin
      sv <= {sv[rd_latency-2:0], state == FETCH};
      bv <= {bv[rd_latency-2:0], state == FETCH && cnt < 6'(BWW)};
      if (sv[rd_latency-1]) srow <= {bus.srch_rd_data, srow[search_blk_w*8-1:rd_port_w*8]};
      if (bv[rd_latency-1]) brow <= {bus.blk_rd_data, brow[block_width*8-1:rd_port_w*8]};
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (bus.bm_start && ready) begin
            state            <= FETCH;
            bus.bm_done      <= 1'b0;
            cnt              <= '0;
            r                <= '0;
            idx              <= bus.blk_index;
            bbase            <= bus.blk_addr;
            sbase            <= bus.srch_addr + 16'(VOFS * srch_stride);
            bus.blk_rd_addr  <= bus.blk_addr;
            bus.srch_rd_addr <= bus.srch_addr + 16'(VOFS * srch_stride);
            for (int k = 0; k < NK; k++) acc[k] <= '0;
          end
        end
        FETCH: begin
          cnt <= cnt + 6'd1;
          if (cnt < 6'(NW - 1)) bus.srch_rd_addr <= bus.srch_rd_addr + 16'd1;
          if (cnt < 6'(BWW - 1)) bus.blk_rd_addr <= bus.blk_rd_addr + 16'd1;
          if (cnt == 6'(NW - 1)) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'(rd_latency - 1)) state <= ACCUM;
        end
        ACCUM: begin
          for (int k = 0; k < NK; k++) acc[k] <= acc[k] + {4'b0, rsad[k]};
          r                <= r + 5'd1;
          cnt              <= '0;
          bbase            <= bbase + 16'(blk_stride);
          sbase            <= sbase + 16'(srch_stride);
          bus.blk_rd_addr  <= bbase + 16'(blk_stride);
          bus.srch_rd_addr <= sbase + 16'(srch_stride);
          state            <= r == 5'(block_height - 1) ? SEARCH : FETCH;
        end
        SEARCH: begin
          cnt <= cnt + 6'd1;
          if (upd) begin
            best  <= acc[cnt];
            bestk <= cnt;
          end
          if (cnt == 6'(NK - 1)) begin
            state            <= DONE;
            bus.result_valid <= 1'b1;
            bus.result_disp  <= upd ? cnt : bestk;
            bus.result_sad   <= upd ? acc[cnt] : best;
            bus.result_index <= idx;
          end
        end
        default: begin
          state            <= IDLE;
          ready            <= 1'b0;
          bus.result_valid <= 1'b0;
          bus.bm_done      <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_block_match_sad_engine.sv
// tb_block_match_sad_engine: directed jobs against a two-port frame-buffer model with fixed 2-cycle latency
module tb_block_match_sad_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] bmem [65536];
  logic [63:0] smem [65536];
  logic [63:0] b1, s1;
  block_match_sad_engine_if bus();
  block_match_sad_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // frame-buffer read ports: address sampled at the edge, data two edges later
  always @(posedge clk) begin
    b1 <= bmem[bus.blk_rd_addr];
    s1 <= smem[bus.srch_rd_addr];
    bus.blk_rd_data <= b1;
    bus.srch_rd_data <= s1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] rw(input int b);
    logic [63:0] v;
    for (int p = 0; p < 8; p++) v[p*8+:8] = 8'(b + p);
    return v;
  endfunction
  task automatic fill(input logic [15:0] ba, input logic [15:0] sa, input logic [63:0] w0,
                      input logic [63:0] w1, input bit ramp, input logic [63:0] sc);
    logic [15:0] a;
    for (int r = 0; r < 16; r++) begin
      a = ba + 16'(r * 30);
      bmem[a] = w0;
      a = a + 16'd1;
      bmem[a] = w1;
      for (int w = 0; w < 8; w++) begin
        a = sa + 16'((8 + r) * 38 + w);
        smem[a] = ramp ? rw(8 * w) : sc;
      end
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".done"}, 32'(bus.bm_done), 1);
    chk({tag, ".valid"}, 32'(bus.result_valid), 0);
    chk({tag, ".disp"}, 32'(bus.result_disp), 0);
    chk({tag, ".sad"}, 32'(bus.result_sad), 0);
    chk({tag, ".index"}, 32'(bus.result_index), 0);
    chk({tag, ".baddr"}, 32'(bus.blk_rd_addr), 0);
    chk({tag, ".saddr"}, 32'(bus.srch_rd_addr), 0);
  endtask
  task automatic run_job(input string tag, input logic [15:0] ba, input logic [15:0] sa,
                         input logic [15:0] ix, input int b2b, input int hold, input int pulse_at,
                         input int ed, input int es);
    int at, vc, rc, np;
    logic [15:0] s0;
    logic [5:0] gd;
    logic [15:0] gs, gi;
    s0 = sa + 16'd304;
    bus.blk_addr = ba;
    bus.srch_addr = sa;
    bus.blk_index = ix;
    bus.bm_start = 1'b1;
    at = 0;
    do begin
      tick;
      at++;
    end while (bus.bm_done && at < 5);
    chk({tag, ".accept"}, 32'(at), b2b ? 2 : 1);
    vc = 0; rc = 0; np = 0; gd = '0; gs = '0; gi = '0;
    for (int n = 1; n <= 400; n++) begin
      bus.bm_start = (n < hold) || (n == pulse_at);
      if (n == 1) begin
        chk({tag, ".saddr1"}, 32'(bus.srch_rd_addr), 32'(s0));
        chk({tag, ".baddr1"}, 32'(bus.blk_rd_addr), 32'(ba));
      end
      if (n == 2) chk({tag, ".baddr2"}, 32'(bus.blk_rd_addr), 32'(16'(ba + 16'd1)));
      if (n == 3) chk({tag, ".baddr3"}, 32'(bus.blk_rd_addr), 32'(16'(ba + 16'd1)));
      if (n == 8) chk({tag, ".saddr8"}, 32'(bus.srch_rd_addr), 32'(16'(s0 + 16'd7)));
      if (n == 12) begin
        chk({tag, ".saddr12"}, 32'(bus.srch_rd_addr), 32'(16'(s0 + 16'd38)));
        chk({tag, ".baddr12"}, 32'(bus.blk_rd_addr), 32'(16'(ba + 16'd30)));
      end
      if (n == 13) chk({tag, ".baddr13"}, 32'(bus.blk_rd_addr), 32'(16'(ba + 16'd31)));
      if (bus.result_valid) begin
        np++;
        vc = n;
        gd = bus.result_disp;
        gs = bus.result_sad;
        gi = bus.result_index;
      end
      if (bus.bm_done) begin
        rc = n;
        break;
      end
      tick;
    end
    bus.bm_start = 1'b0;
    chk({tag, ".rise"}, 32'(rc), 227);
    chk({tag, ".vcyc"}, 32'(vc), 226);
    chk({tag, ".pulses"}, 32'(np), 1);
    chk({tag, ".disp"}, 32'(gd), 32'(ed));
    chk({tag, ".sad"}, 32'(gs), 32'(es));
    chk({tag, ".index"}, 32'(gi), 32'(ix));
    chk({tag, ".hold"}, 32'(bus.result_disp), 32'(ed));
  endtask
  initial begin
    int np;
    bus.bm_start = 1'b0;
    bus.blk_addr = '0;
    bus.srch_addr = '0;
    bus.blk_index = '0;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk_idle("reset");
    fill(16'd100, 16'd500, rw(20), rw(28), 1'b1, '0);
    run_job("exact", 16'd100, 16'd500, 16'd7, 0, 1, 0, 20, 0);
    fill(16'd1000, 16'd2000, {8{8'h40}}, {8{8'h40}}, 1'b0, {8{8'h40}});
    run_job("tie_b2b", 16'd1000, 16'd2000, 16'd8, 1, 1, 0, 0, 0);
    tick;
    fill(16'd3000, 16'hFFF0, {8{8'h10}}, {8{8'h10}}, 1'b0, {8{8'h13}});
    run_job("sad_wrap", 16'd3000, 16'hFFF0, 16'd9, 0, 1, 0, 0, 768);
    tick;
    fill(16'd200, 16'd700, rw(48), rw(56), 1'b1, '0);
    run_job("edge48", 16'd200, 16'd700, 16'd10, 0, 1, 0, 48, 0);
    tick;
    fill(16'd100, 16'd500, rw(20), rw(28), 1'b1, '0);
    run_job("hshake", 16'd100, 16'd500, 16'h1234, 0, 3, 100, 20, 0);
    tick;
    bus.blk_index = 16'h0099;
    bus.bm_start = 1'b1;
    tick;
    bus.bm_start = 1'b0;
    chk("rst.started", 32'(bus.bm_done), 0);
    repeat (99) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_idle("rst.in");
    tick;
    chk_idle("rst.after");
    np = 0;
    for (int n = 0; n < 300; n++) begin
      if (bus.result_valid) np++;
      tick;
    end
    chk("rst.nopulse", 32'(np), 0);
    fill(16'd200, 16'd700, rw(48), rw(56), 1'b1, '0);
    run_job("post_rst", 16'd200, 16'd700, 16'h0055, 0, 1, 0, 48, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
